// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC/BadVAddr/Count/Compare with exception, ERET and MTC0/MFC0 handling.
// Optional macro CP0_TIMER_INT_EN enables the Count/Compare timer interrupt (TI) onto IP7.
module cp0_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        is_exception,
  input  logic        is_bd,
  input  logic [4:0]  excep_code,
  input  logic [31:0] excep_pc,
  input  logic        we_badvaddr,
  input  logic [31:0] badvaddr,
  input  logic        eret,
  input  logic [5:0]  ext_int,
  output logic        is_ie,
  output logic        is_exl,
  output logic [7:0]  int_mask,
  output logic [1:0]  soft_int,
  output logic [5:0]  hardware_int,
  output logic [31:0] epc
);

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [XLEN-1:0] badvaddr_q, badvaddr_d;
  logic [XLEN-1:0] count_q,    count_d;
  logic [XLEN-1:0] compare_q,  compare_d;
  logic [XLEN-1:0] epc_q,      epc_d;
  logic            tick_q,     tick_d;
  logic [7:0]      im_q,       im_d;
  logic            exl_q,      exl_d;
  logic            ie_q,       ie_d;
  logic            bd_q,       bd_d;
  logic [5:0]      ip_hw_q,    ip_hw_d;
  logic [1:0]      ip_sw_q,    ip_sw_d;
  logic [4:0]      exccode_q,  exccode_d;
  logic            timer_int;

`ifdef CP0_TIMER_INT_EN
  logic ti_q, ti_d;
  assign timer_int = ti_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ti_q <= 1'b0;
    else         ti_q <= ti_d;
  end
`else
  assign timer_int = 1'b0;
`endif

  // Next-state: free-running timer/interrupt sampling, then exception > eret > MTC0.
  always_comb begin
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    tick_d     = ~tick_q;
    count_d    = tick_q ? count_q + 32'd1 : count_q;
    ip_hw_d    = {ext_int[5] | timer_int, ext_int[4:0]};
`ifdef CP0_TIMER_INT_EN
    ti_d       = ti_q | (count_q == compare_q);
`endif

    if (is_exception) begin
      exl_d     = 1'b1;
      exccode_d = excep_code;
      // Nested exceptions keep the original return point and BD.
      if (!exl_q) begin
        epc_d = excep_pc;
        bd_d  = is_bd;
      end
      if (we_badvaddr) begin
        badvaddr_d = badvaddr;
      end
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (we) begin
      case (waddr)
        REG_COUNT: begin
          count_d = wdata;
          tick_d  = 1'b0;
        end
        REG_COMPARE: begin
          compare_d = wdata;
`ifdef CP0_TIMER_INT_EN
          ti_d      = 1'b0;
`endif
        end
        REG_STATUS: begin
          im_d  = wdata[15:8];
          exl_d = wdata[1];
          ie_d  = wdata[0];
        end
        REG_CAUSE: begin
          ip_sw_d = wdata[9:8];
        end
        REG_EPC: begin
          epc_d = wdata;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      tick_q     <= 1'b0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      tick_q     <= tick_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
    end
  end

  // MFC0 read mux; no bypass from a same-cycle write.
  always_comb begin
    rdata = '0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr_q;
      REG_COUNT:    rdata = count_q;
      REG_COMPARE:  rdata = compare_q;
      REG_STATUS:   rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
      REG_CAUSE:    rdata = {bd_q, timer_int, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};
      REG_EPC:      rdata = epc_q;
      default:      rdata = '0;
    endcase
  end

  assign is_ie        = ie_q;
  assign is_exl       = exl_q;
  assign int_mask     = im_q;
  assign soft_int     = ip_sw_q;
  assign hardware_int = ip_hw_q;
  assign epc          = epc_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: architectural-word model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        resetn;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        is_exception;
  logic        is_bd;
  logic [4:0]  excep_code;
  logic [31:0] excep_pc;
  logic        we_badvaddr;
  logic [31:0] badvaddr;
  logic        eret;
  logic [5:0]  ext_int;
  logic        is_ie;
  logic        is_exl;
  logic [7:0]  int_mask;
  logic [1:0]  soft_int;
  logic [5:0]  hardware_int;
  logic [31:0] epc;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

`ifdef CP0_TIMER_INT_EN
  localparam logic [31:0] TI_BITS = 32'h4000_8000;
  localparam logic        TMR     = 1'b1;
`else
  localparam logic [31:0] TI_BITS = 32'h0000_0000;
  localparam logic        TMR     = 1'b0;
`endif
  localparam logic [5:0]  HW_TI   = {TMR, 5'b0};

  cp0_regfile dut (
    .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .is_exception(is_exception), .is_bd(is_bd),
    .excep_code(excep_code), .excep_pc(excep_pc), .we_badvaddr(we_badvaddr),
    .badvaddr(badvaddr), .eret(eret), .ext_int(ext_int), .is_ie(is_ie),
    .is_exl(is_exl), .int_mask(int_mask), .soft_int(soft_int),
    .hardware_int(hardware_int), .epc(epc)
  );

  always #5 clk = ~clk;

  // Model holds whole architectural register words.
  typedef struct packed {
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] bad;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tick;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.status = 32'h0040_0000;
    return r;
  endfunction

  function automatic model_t model_next(model_t c);
    model_t n;
    n = c;
    n.tick = ~c.tick;
    if (c.tick) n.count = c.count + 32'd1;
`ifdef CP0_TIMER_INT_EN
    if (c.count == c.compare) n.cause[30] = 1'b1;
`endif
    n.cause[15:10] = {ext_int[5] | c.cause[30], ext_int[4:0]};
    if (is_exception) begin
      if (!c.status[1]) begin
        n.epc       = excep_pc;
        n.cause[31] = is_bd;
      end
      n.status[1]   = 1'b1;
      n.cause[6:2]  = excep_code;
      if (we_badvaddr) n.bad = badvaddr;
    end else if (eret) begin
      n.status[1] = 1'b0;
    end else if (we) begin
      case (waddr)
        5'd9:  begin n.count = wdata; n.tick = 1'b0; end
        5'd11: begin n.compare = wdata; n.cause[30] = 1'b0; end
        5'd12: n.status = (wdata & 32'h0000_FF03) | 32'h0040_0000;
        5'd13: n.cause[9:8] = wdata[9:8];
        5'd14: n.epc = wdata;
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] model_read(model_t c, logic [4:0] a);
    case (a)
      5'd8:  return c.bad;
      5'd9:  return c.count;
      5'd11: return c.compare;
      5'd12: return c.status;
      5'd13: return c.cause;
      5'd14: return c.epc;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m <= model_reset();
    else         m <= model_next(m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_rdata",    rdata,              model_read(m, raddr));
      check("m_is_ie",    32'(is_ie),         32'(m.status[0]));
      check("m_is_exl",   32'(is_exl),        32'(m.status[1]));
      check("m_int_mask", 32'(int_mask),      32'(m.status[15:8]));
      check("m_soft_int", 32'(soft_int),      32'(m.cause[9:8]));
      check("m_hw_int",   32'(hardware_int),  32'(m.cause[15:10]));
      check("m_epc",      epc,                m.epc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    check(name, rdata, exp);
  endtask

  initial begin
    resetn = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    is_exception = 1'b0; is_bd = 1'b0; excep_code = '0; excep_pc = '0;
    we_badvaddr = 1'b0; badvaddr = '0; eret = 1'b0; ext_int = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_en = 1'b1;

    // Reset state
    rd_chk("rst_status", 5'd12, 32'h0040_0000);
    rd_chk("rst_cause",  5'd13, 32'h0);
    rd_chk("rst_epc",    5'd14, 32'h0);
    check("rst_outs", 32'({is_ie, is_exl, int_mask, soft_int, hardware_int}), 32'h0);
    check("rst_epc_out", epc, 32'h0);

    // Status write and interrupt sampling
    mtc0(5'd12, 32'h0000_FF01);
    check("ie_set", 32'(is_ie), 32'h1);
    check("im_set", 32'(int_mask), 32'hFF);
    ext_int = 6'b000100;
    cyc();
    check("hw_int", 32'(hardware_int), 32'(6'b000100 | HW_TI));
    rd_chk("cause_ip", 5'd13, 32'h0000_1000 | TI_BITS);
    ext_int = '0;
    cyc();

    // First exception
    is_exception = 1'b1; excep_pc = 32'hBFC0_0100; is_bd = 1'b1;
    excep_code = 5'h04; we_badvaddr = 1'b1; badvaddr = 32'h3;
    cyc();
    is_exception = 1'b0; we_badvaddr = 1'b0; is_bd = 1'b0;
    check("exc1_epc", epc, 32'hBFC0_0100);
    check("exc1_exl", 32'(is_exl), 32'h1);
    rd_chk("exc1_cause", 5'd13, 32'h8000_0010 | TI_BITS);
    rd_chk("exc1_bad",   5'd8,  32'h3);

    // Nested exception keeps EPC and BD
    is_exception = 1'b1; excep_pc = 32'h0000_1234; is_bd = 1'b0; excep_code = 5'h0C;
    cyc();
    is_exception = 1'b0;
    check("exc2_epc", epc, 32'hBFC0_0100);
    rd_chk("exc2_cause", 5'd13, 32'h8000_0030 | TI_BITS);
    rd_chk("exc2_bad",   5'd8,  32'h3);

    // eret drops a same-cycle MTC0
    eret = 1'b1; we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
    cyc();
    eret = 1'b0; we = 1'b0;
    check("eret_exl", 32'(is_exl), 32'h0);
    check("eret_epc", epc, 32'hBFC0_0100);

    // Exception beats eret
    is_exception = 1'b1; eret = 1'b1; excep_pc = 32'h0000_2000; is_bd = 1'b0; excep_code = 5'h08;
    cyc();
    is_exception = 1'b0; eret = 1'b0;
    check("exer_exl", 32'(is_exl), 32'h1);
    check("exer_epc", epc, 32'h0000_2000);
    rd_chk("exer_cause", 5'd13, 32'h0000_0020 | TI_BITS);
    eret = 1'b1;
    cyc();
    eret = 1'b0;
    check("eret2_exl", 32'(is_exl), 32'h0);

    // Read-only and unimplemented registers, writable-field masks
    mtc0(5'd8, 32'hFFFF_FFFF);
    rd_chk("bad_ro", 5'd8, 32'h3);
    mtc0(5'd5, 32'h1);
    rd_chk("unimpl", 5'd5, 32'h0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    check("soft_int", 32'(soft_int), 32'h3);
    rd_chk("cause_wr", 5'd13, 32'h0000_0320 | TI_BITS);
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd_chk("status_wr", 5'd12, 32'h0040_FF03);
    check("status_exl", 32'(is_exl), 32'h1);

    // Count/Compare timer
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'h5);
    repeat (9) cyc();
    rd_chk("cnt_5", 5'd9, 32'h5);
    rd_chk("ti_pre", 5'd13, 32'h0000_0320);
    cyc();
    rd_chk("ti_set", 5'd13, 32'h0000_0320 | (TMR ? 32'h4000_0000 : 32'h0));
    cyc();
    check("hw_ti", 32'(hardware_int), 32'(HW_TI));
    mtc0(5'd11, 32'h0000_1000);
    rd_chk("ti_clr", 5'd13, 32'h0000_0320 | (TMR ? 32'h0000_8000 : 32'h0));
    cyc();
    check("hw_ti_clr", 32'(hardware_int), 32'h0);

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd_chk("wrap0", 5'd9, 32'hFFFF_FFFF);
    cyc();
    rd_chk("wrap1", 5'd9, 32'hFFFF_FFFF);
    cyc();
    rd_chk("wrap2", 5'd9, 32'h0);

    // Asynchronous reset mid-cycle
    cyc();
    #1;
    resetn = 1'b0;
    #1;
    check("arst_epc", epc, 32'h0);
    rd_chk("arst_status", 5'd12, 32'h0040_0000);
    check("arst_exl", 32'(is_exl), 32'h0);
    repeat (2) cyc();
    resetn = 1'b1;
    repeat (3) cyc();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
